// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator. Each channel has a period and a high
// time; new settings are shadowed and only take effect at a wrap, a disable or sync.

module pulse_gen_ch #(
    parameter int CW      = 16,
    parameter int DEF_DIV = 250
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          sync,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    input  logic [CW-1:0] wr_hi,
    output logic          pending,
    output logic          pulse
);
    localparam logic [CW-1:0] RST_DIV = CW'(DEF_DIV);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] div_q, div_d, hi_q, hi_d;
    logic [CW-1:0] sdiv_q, sdiv_d, shi_q, shi_d;
    logic [CW-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
    logic          pend_q, pend_d, pulse_q, pulse_d;
    logic [CW-1:0] eff_div, eff_hi, hi_len;
    logic          wrap;

    // Values that will be active after this edge if it is an apply point.
    assign eff_div = pend_q ? sdiv_q : div_q;
    assign eff_hi  = pend_q ? shi_q : hi_q;
    assign hi_len  = (eff_hi < eff_div) ? eff_hi : eff_div;
    assign wrap    = (cnt_q == div_q - ONE);

    always_comb begin
        div_d   = div_q;
        hi_d    = hi_q;
        sdiv_d  = sdiv_q;
        shi_d   = shi_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pulse_d = pulse_q;
        if (sync || !en) begin
            cnt_d   = '0;
            wcnt_d  = '0;
            pulse_d = 1'b0;
            div_d   = eff_div;
            hi_d    = eff_hi;
            pend_d  = 1'b0;
        end else if (wrap) begin
            cnt_d   = '0;
            div_d   = eff_div;
            hi_d    = eff_hi;
            pend_d  = 1'b0;
            pulse_d = (eff_hi != '0);
            wcnt_d  = (eff_hi != '0) ? hi_len - ONE : '0;
        end else begin
            cnt_d = cnt_q + ONE;
            if (wcnt_q != '0) begin
                wcnt_d  = wcnt_q - ONE;
                pulse_d = 1'b1;
            end else begin
                pulse_d = 1'b0;
            end
        end
        // A write is only accepted while nothing is pending, so it never
        // collides with an apply on the same edge.
        if (wr) begin
            sdiv_d = wr_div;
            shi_d  = wr_hi;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= RST_DIV;
            hi_q    <= ONE;
            sdiv_q  <= RST_DIV;
            shi_q   <= ONE;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            hi_q    <= hi_d;
            sdiv_q  <= sdiv_d;
            shi_q   <= shi_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pending = pend_q;
    assign pulse   = pulse_q;
endmodule

module pulse_gen_multi #(
    parameter int  NCH     = 4,
    parameter int  CW      = 16,
    parameter int  DEF_DIV = 250,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic [CW-1:0]  cfg_hi,
    output logic           cfg_err,
    output logic [NCH-1:0] pulse
);
    logic [NCH-1:0] pend, wr_sel;
    logic           cfg_in_range, cfg_ok, cfg_acc;
    logic           cfg_err_d, cfg_err_q;

    // Out-of-range channels report ready so the bad write is accepted and flagged.
    always_comb begin
        cfg_ready    = 1'b1;
        cfg_in_range = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_ch == CHW'(i)) begin
                cfg_in_range = 1'b1;
                cfg_ready    = ~pend[i];
            end
        end
    end

    assign cfg_ok    = cfg_in_range && (cfg_div != '0);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign cfg_err_d = cfg_acc && !cfg_ok;

    always_ff @(posedge clk) begin
        if (reset) cfg_err_q <= 1'b0;
        else       cfg_err_q <= cfg_err_d;
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign wr_sel[g] = cfg_acc && cfg_ok && (cfg_ch == CHW'(g));
        pulse_gen_ch #(.CW(CW), .DEF_DIV(DEF_DIV)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .en      (en[g]),
            .sync    (sync),
            .wr      (wr_sel[g]),
            .wr_div  (cfg_div),
            .wr_hi   (cfg_hi),
            .pending (pend[g]),
            .pulse   (pulse[g])
        );
    end
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: directed vector table, hand-built corner sequences and
// random traffic, all checked against an edge-counting reference model.

module tb_pulse_gen_multi;
    localparam int NCH     = 5;
    localparam int CW      = 16;
    localparam int DEF_DIV = 250;
    localparam int CHW     = 3;

    logic           clk = 1'b0;
    logic           reset, sync, cfg_valid, cfg_ready, cfg_err;
    logic [NCH-1:0] en, pulse;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div, cfg_hi;

    always #5 clk = ~clk;

    pulse_gen_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_hi(cfg_hi), .cfg_err(cfg_err), .pulse(pulse)
    );

    // Reference model: per channel, edges since the last period start and the
    // length of the high window opened at the last wrap.
    int             m_div[NCH], m_hi[NCH], m_sdiv[NCH], m_shi[NCH];
    int             m_e[NCH], m_hlen[NCH];
    bit             m_pend[NCH];
    logic [NCH-1:0] m_pulse;
    logic           m_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic s_rdy;

    function automatic logic m_ready(int ch);
        if (ch >= NCH) return 1'b1;
        return !m_pend[ch];
    endfunction

    function automatic void model_edge();
        int ch;
        bit acc, ok, restart;
        ch = int'(cfg_ch);
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = DEF_DIV; m_hi[i] = 1; m_sdiv[i] = DEF_DIV; m_shi[i] = 1;
                m_pend[i] = 1'b0; m_e[i] = 0; m_hlen[i] = 0;
            end
            m_pulse = '0;
            m_err   = 1'b0;
            return;
        end
        acc = cfg_valid && m_ready(ch);
        ok  = (ch < NCH) && (cfg_div != 0);
        for (int i = 0; i < NCH; i++) begin
            restart = sync || !en[i];
            if (restart || (m_e[i] + 1 == m_div[i])) begin
                if (m_pend[i]) begin
                    m_div[i] = m_sdiv[i]; m_hi[i] = m_shi[i]; m_pend[i] = 1'b0;
                end
                m_e[i] = 0;
                if (restart) begin
                    m_hlen[i] = 0;
                    m_pulse[i] = 1'b0;
                end else begin
                    m_hlen[i] = (m_hi[i] < m_div[i]) ? m_hi[i] : m_div[i];
                    m_pulse[i] = (m_hlen[i] > 0);
                end
            end else begin
                m_e[i]++;
                m_pulse[i] = (m_e[i] < m_hlen[i]);
            end
        end
        if (acc && ok) begin
            m_sdiv[ch] = int'(cfg_div); m_shi[ch] = int'(cfg_hi); m_pend[ch] = 1'b1;
        end
        m_err = acc && !ok;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_rdy = cfg_ready;
        chk("cfg_ready_vs_model", 32'(s_rdy), 32'(m_ready(int'(cfg_ch))));
        @(posedge clk);
        model_edge();
        #1;
        chk("pulse_vs_model", 32'(pulse), 32'(m_pulse));
        chk("cfg_err_vs_model", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic cfg_write(input int ch, input int dv, input int h);
        cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_div = CW'(dv); cfg_hi = CW'(h);
        tick();
        cfg_valid = 1'b0;
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic           cv;
        logic [CHW-1:0] ch;
        logic [CW-1:0]  dv;
        logic [CW-1:0]  hi;
        logic           rdy;
        logic [NCH-1:0] p;
        logic           err;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // ch1 gets div=5 hi=2 while disabled; a second write stalls on pending;
        // two bad writes are flagged without disturbing ch1.
        tbl[0]  = '{5'b00000, 1'b1, 3'd1, 16'd5, 16'd2, 1'b1, 5'b00000, 1'b0};
        tbl[1]  = '{5'b00000, 1'b1, 3'd1, 16'd9, 16'd9, 1'b0, 5'b00000, 1'b0};
        tbl[2]  = '{5'b00010, 1'b0, 3'd1, 16'd0, 16'd0, 1'b1, 5'b00000, 1'b0};
        tbl[3]  = '{5'b00010, 1'b0, 3'd1, 16'd0, 16'd0, 1'b1, 5'b00000, 1'b0};
        tbl[4]  = '{5'b00010, 1'b0, 3'd1, 16'd0, 16'd0, 1'b1, 5'b00000, 1'b0};
        tbl[5]  = '{5'b00010, 1'b0, 3'd1, 16'd0, 16'd0, 1'b1, 5'b00000, 1'b0};
        tbl[6]  = '{5'b00010, 1'b0, 3'd1, 16'd0, 16'd0, 1'b1, 5'b00010, 1'b0};
        tbl[7]  = '{5'b00010, 1'b0, 3'd1, 16'd0, 16'd0, 1'b1, 5'b00010, 1'b0};
        tbl[8]  = '{5'b00010, 1'b1, 3'd3, 16'd0, 16'd4, 1'b1, 5'b00000, 1'b1};
        tbl[9]  = '{5'b00010, 1'b1, 3'd5, 16'd7, 16'd1, 1'b1, 5'b00000, 1'b1};
        tbl[10] = '{5'b00010, 1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 5'b00000, 1'b0};
        tbl[11] = '{5'b00010, 1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 5'b00010, 1'b0};
        tbl[12] = '{5'b00010, 1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 5'b00010, 1'b0};
        tbl[13] = '{5'b00010, 1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 5'b00000, 1'b0};

        reset = 1'b1; sync = 1'b0; en = '0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_hi = '0;
        model_edge();
        tick(); tick();
        chk("reset_pulse", 32'(pulse), 32'd0);
        chk("reset_err", 32'(cfg_err), 32'd0);
        chk("reset_ready", 32'(s_rdy), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            en = tbl[i].en; cfg_valid = tbl[i].cv; cfg_ch = tbl[i].ch;
            cfg_div = tbl[i].dv; cfg_hi = tbl[i].hi;
            tick();
            chk($sformatf("tbl%0d_ready", i), 32'(s_rdy), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_pulse", i), 32'(pulse), 32'(tbl[i].p));
            chk($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(tbl[i].err));
        end
        cfg_valid = 1'b0;

        // Default divide-by-250 tick on ch0.
        reset = 1'b1; en = 5'b00001;
        tick(); tick();
        reset = 1'b0;
        for (int k = 1; k <= 760; k++) begin
            tick();
            chk($sformatf("def250_k%0d", k), 32'(pulse),
                (k == 250 || k == 500 || k == 750) ? 32'd1 : 32'd0);
        end

        // ch2 at div=10, retimed to div=4 mid-period.
        cfg_write(2, 10, 1);
        tick();
        en[2] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            cfg_valid = (k == 4); cfg_ch = 3'd2; cfg_div = 16'd4; cfg_hi = 16'd1;
            tick();
            chk($sformatf("retime_rdy_k%0d", k), 32'(s_rdy), (k >= 5 && k <= 10) ? 32'd0 : 32'd1);
            chk($sformatf("retime_p2_k%0d", k), 32'(pulse[2]),
                (k == 10 || k == 14 || k == 18 || k == 22) ? 32'd1 : 32'd0);
        end
        cfg_valid = 1'b0;

        // ch0 with hi > div stays high, then hi=0 takes effect at the next wrap.
        en[0] = 1'b0;
        cfg_write(0, 8, 20);
        tick();
        en[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cfg_valid = (k == 21); cfg_ch = 3'd0; cfg_div = 16'd8; cfg_hi = 16'd0;
            tick();
            chk($sformatf("hiwide_p0_k%0d", k), 32'(pulse[0]), (k >= 8 && k < 24) ? 32'd1 : 32'd0);
        end
        cfg_valid = 1'b0;

        // sync mid-period applies a pending write and restarts every channel.
        en = '0;
        cfg_write(1, 5, 3);
        cfg_write(3, 7, 2);
        tick();
        en = '1;
        for (int k = 1; k <= 7; k++) begin
            if (k == 6) begin
                cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd3; cfg_hi = 16'd1;
            end else begin
                cfg_valid = 1'b0;
            end
            sync = (k == 7);
            tick();
            if (k == 6) chk("presync_p1", 32'(pulse[1]), 32'd1);
        end
        chk("sync_clear", 32'(pulse), 32'd0);
        sync = 1'b0; cfg_valid = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            chk($sformatf("sync_p1_j%0d", j), 32'(pulse[1]), (j % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("sync_p3_j%0d", j), 32'(pulse[3]), (j == 7 || j == 8) ? 32'd1 : 32'd0);
        end

        // Same, but reset lands on the sync edge: pending write is lost.
        for (int k = 1; k <= 6; k++) begin
            cfg_valid = (k == 5); cfg_ch = 3'd1; cfg_div = 16'd6; cfg_hi = 16'd1;
            sync = (k == 6); reset = (k == 6);
            tick();
            if (k == 6) chk("prereset_rdy1", 32'(s_rdy), 32'd0);
        end
        chk("syncrst_clear", 32'(pulse), 32'd0);
        sync = 1'b0; reset = 1'b0; cfg_valid = 1'b0;
        for (int j = 1; j <= 252; j++) begin
            tick();
            if (j == 1) chk("postreset_rdy1", 32'(s_rdy), 32'd1);
            chk($sformatf("syncrst_p1_j%0d", j), 32'(pulse[1]), (j == 250) ? 32'd1 : 32'd0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 499) == 0);
            sync  = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch    = CHW'($urandom_range(0, 7));
            cfg_div   = CW'($urandom_range(0, 12));
            cfg_hi    = CW'($urandom_range(0, 14));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_gen_multi.md
PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CW, default 16: divider and width counter bit width.
REQ-003 SHALL have parameter DEF_DIV, default 250: reset divider for every channel; must be nonzero and fit in CW bits.
REQ-004 SHALL have derived localparam CHW = max(1, clog2(NCH)).
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  NCH  per-channel run enable.
REQ-008 SHALL have port sync  input  1  single-cycle phase realign strobe for all channels.
REQ-009 SHALL have port cfg_valid  input  1  config write request.
REQ-010 SHALL have port cfg_ready  output  1  config write can be accepted.
REQ-011 SHALL have port cfg_ch  input  CHW  target channel index.
REQ-012 SHALL have port cfg_div  input  CW  new period in cycles.
REQ-013 SHALL have port cfg_hi  input  CW  new high time in cycles.
REQ-014 SHALL have port cfg_err  output  1  one-cycle flag for a rejected config write.
REQ-015 SHALL have port pulse  output  NCH  registered per-channel pulse outputs.

Function
REQ-016 Each channel SHALL hold active registers div and hi, shadow registers sdiv and shi, a pending flag, a period counter cnt, and a width counter wcnt.
REQ-017 When en[i] is sampled low, the block SHALL clear cnt, wcnt and pulse[i] to 0 on that edge and hold them at 0; any pending value SHALL be copied to the active registers and pending cleared.
REQ-018 When en[i] is sampled high, cnt SHALL advance on each edge: if cnt==div-1, cnt becomes 0 (a wrap); otherwise it increments by 1.
REQ-019 On a wrap with hi!=0, pulse[i] SHALL be 1 after that edge and wcnt SHALL load min(hi,div)-1.
REQ-020 On a non-wrap edge, if wcnt!=0 then wcnt SHALL decrement and pulse[i] SHALL stay 1; otherwise pulse[i] SHALL be 0.
REQ-021 Net behaviour: the first rising edge of pulse[i] SHALL occur after the div-th consecutive edge with en[i] high.
REQ-022 pulse[i] SHALL then have period div and high time min(hi,div) cycles.
REQ-023 If hi>=div, pulse[i] SHALL remain 1 continuously after the first wrap.
REQ-024 If hi==0, pulse[i] SHALL never assert.
REQ-025 With div==1 and hi==1, pulse[i] SHALL be 1 on every cycle after the first enabled edge.
REQ-026 cfg_ready SHALL be the inverse of the pending flag of the channel selected by cfg_ch, evaluated combinationally; for an out-of-range cfg_ch it SHALL be 1.
REQ-027 A write SHALL be accepted on an edge where cfg_valid and cfg_ready are both 1.
REQ-028 An accepted write with cfg_ch>=NCH or cfg_div==0 SHALL change no state and SHALL set cfg_err to 1 for exactly the next cycle; otherwise cfg_err SHALL be 0.
REQ-029 A valid accepted write SHALL load sdiv and shi and set pending.
REQ-030 A pending value SHALL be transferred to div and hi, and pending cleared, at the next wrap edge of that channel (glitch-free period change), at an edge where en[i] is low, or at sync.
REQ-031 A write arriving on the same edge as a wrap of the same channel SHALL set pending; it is applied at the following wrap, not the current one.
REQ-032 When sync is 1, every channel SHALL on that edge clear cnt, wcnt and pulse[i] to 0 and apply any pending value.
REQ-033 sync SHALL take priority over wrap and over en; after sync each enabled channel restarts as in REQ-021.
REQ-034 Channels SHALL be fully independent apart from sync and the shared config port.

Reset
REQ-035 On reset, every channel SHALL set div to DEF_DIV, hi to 1, sdiv to DEF_DIV, shi to 1, pending to 0, cnt to 0, wcnt to 0 and pulse to 0.
REQ-036 On reset, cfg_err SHALL be 0.
REQ-037 reset SHALL take priority over sync, en and config writes; a write presented during reset SHALL be discarded.
REQ-038 After reset is released, a channel with en high SHALL behave exactly like a legacy divide-by-250 single-cycle tick.

Verification
REQ-039 Reset, then en=1 on channel 0 with defaults -> pulse[0] is 1 for one cycle after edge 250, then after edges 500 and 750, and 0 otherwise.
REQ-040 Write ch1 div=5 hi=2 while ch1 is disabled, then enable -> pulse[1] is high at edges 5-6, then 10-11, and cfg_err stays 0.
REQ-041 ch2 running div=10 hi=1; write div=4 at cnt==3 -> the old period completes at edge 10, then pulses repeat every 4 cycles, and cfg_ready for ch2 is 0 until that wrap.
REQ-042 Write cfg_div=0, then write cfg_ch=NCH -> each write is accepted with cfg_err high for one cycle, and no channel timing changes.
REQ-043 ch0 div=8 hi=20 -> pulse[0] is continuously 1 after edge 8; write hi=0 -> pulse[0] falls after the next wrap and never reasserts.
REQ-044 Assert sync mid-period on all channels, with reset asserted on the same edge in a second run -> all pulses clear and the next pulses land div edges after sync; with reset, the reset values are taken and pending writes are lost.
